// File: rtl/dmem_loader_if.sv
// Byte-stream input and D_Memory write port of the data-memory loader.
// The master side is the loader; the slave side is the stream source plus the memory.
interface dmem_loader_if #(
  parameter int AW = 8
);
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;

  modport master (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_loader.sv
// Data-memory loader: streams matrix and vector bytes into D_Memory, zero-fills the result
// words, releases the CPU and counts its run cycles until it reports done.
module dmem_loader #(
  parameter int M  = 3,
  parameter int N  = 4,
  parameter int AW = 8
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          start,
  dmem_loader_if.master bus,
  output logic          cpu_run,
  input  logic          cpu_done,
  output logic          busy,
  output logic          finished,
  output logic [15:0]   run_cycles
);

  localparam int LOAD_BYTES = 4 * (M * N + N);
  localparam int RES_BYTES  = 4 * M;
  localparam logic [AW:0] LAST_LOAD = (AW + 1)'(LOAD_BYTES - 1);
  localparam logic [AW:0] END_PTR   = (AW + 1)'(LOAD_BYTES + RES_BYTES);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, RUN, DONE} state_t;

  state_t      state;
  logic [AW:0] ptr;        // one spare bit so END_PTR is representable when 2**AW is tight
  logic        first_run;

  assign bus.s_ready = (state == LOAD);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      first_run     <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_run       <= 1'b0;
      busy          <= 1'b0;
      finished      <= 1'b0;
      run_cycles    <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            ptr        <= '0;
            run_cycles <= '0;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.s_valid) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ptr[AW-1:0];
            bus.mem_wdata <= bus.s_data;
            ptr           <= ptr + 1'b1;
            if (ptr == LAST_LOAD) state <= CLEAR;
          end
        end
        CLEAR: begin
          // ptr continues from LOAD_BYTES straight into the result region
          if (ptr < END_PTR) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ptr[AW-1:0];
            bus.mem_wdata <= '0;
            ptr           <= ptr + 1'b1;
          end else begin
            state     <= RUN;
            cpu_run   <= 1'b1;
            first_run <= 1'b1;
          end
        end
        RUN: begin
          first_run <= 1'b0;
          // done is ignored in the first cycle: the CPU has only just left reset
          if (cpu_done && !first_run) begin
            state    <= DONE;
            busy     <= 1'b0;
            finished <= 1'b1;
          end else if (run_cycles != '1) begin
            run_cycles <= run_cycles + 16'd1;
          end
        end
        DONE: begin
          if (start) begin
            state      <= LOAD;
            ptr        <= '0;
            run_cycles <= '0;
            cpu_run    <= 1'b0;
            finished   <= 1'b0;
            busy       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
